tile_skew_loader: RTL and testbench
===================================

TILE_SKEW_LOADER -- requirements
Module: tile_skew_loader

Interface
REQ-001 SHALL have parameter N, default 8: tile dimension, i.e. the number of systolic lanes.
REQ-002 SHALL have parameter DW, default 32: element width in bits.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an upstream AXI-stream beat is present.
REQ-006 SHALL have port in_data, input, N*DW bits: one tile row; element k occupies bits [k*DW +: DW].
REQ-007 SHALL have port in_ready, output, 1 bit: a beat is accepted when in_valid && in_ready.
REQ-008 SHALL have port sa_ready, input, 1 bit: the systolic array can accept a new tile.
REQ-009 SHALL have port sa_data, output, N x DW bits: lane i element.
REQ-010 SHALL have port sa_valid, output, N bits: lane i element valid.
REQ-011 SHALL have port sa_start, output, 1 bit: first drain cycle of a tile.
REQ-012 SHALL have port sa_last, output, 1 bit: final drain cycle of a tile.
REQ-013 SHALL have port busy, output, 1 bit: a drain is in progress.

Function
REQ-014 SHALL hold two N x N x DW tile buffers (ping-pong), each with a full flag.
REQ-015 Fill: accepted beat r (0..N-1) SHALL write row r of buffer wr_sel; the row counter increments per accepted beat.
REQ-016 On acceptance of beat N-1, full[wr_sel] SHALL be set, the row counter SHALL wrap to 0 and wr_sel SHALL toggle.
REQ-017 in_ready SHALL equal !full[wr_sel] and be a function of registered state only.
REQ-018 Drain FSM SHALL have states IDLE and DRAIN; drain counter cnt runs 0..2N-2 (0..14 at N=8).
REQ-019 IDLE -> DRAIN, cnt=0, SHALL occur when full[rd_sel] && sa_ready.
REQ-020 While in DRAIN, cnt SHALL increment every cycle regardless of sa_ready; no mid-tile backpressure.
REQ-021 With A = buffer rd_sel, in DRAIN at cnt=t, lane i SHALL drive sa_data[i] = A[i][t-i] with sa_valid[i] = 1 when 0 <= t-i <= N-1.
REQ-022 Outside that window, lane i SHALL drive sa_data[i] = 0 and sa_valid[i] = 0.
REQ-023 sa_start SHALL be high only at DRAIN cnt=0, sa_last only at DRAIN cnt=2N-2, and busy SHALL equal (state==DRAIN).
REQ-024 At cnt=2N-2, full[rd_sel] SHALL clear and rd_sel SHALL toggle.
REQ-025 At cnt=2N-2, the next state SHALL be DRAIN with cnt=0 if the other buffer is full and sa_ready; otherwise IDLE.
REQ-026 Back-to-back tiles SHALL have no gap cycle.
REQ-027 All sa_* outputs SHALL be zero in IDLE.
REQ-028 All sa_* outputs SHALL be functions of registered state only; there SHALL be no combinational path from in_* or sa_ready.
REQ-029 Simultaneous fill-complete on one buffer and drain-complete on the other SHALL both take effect in the same cycle.
REQ-030 A buffer freed at cycle c SHALL show in_ready=1 from cycle c+1.
REQ-031 When both buffers are full, in_ready SHALL be 0 and in_data SHALL be ignored.
REQ-032 in_valid with in_ready=0 SHALL not alter any state.

Reset
REQ-033 On rst: state=IDLE, cnt=0, wr_sel=rd_sel=0, row counter=0, both full flags=0.
REQ-034 On rst, all sa_* outputs and busy SHALL be 0 and in_ready SHALL be 1 in the following cycle.
REQ-035 Buffer contents SHALL need no reset.
REQ-036 rst mid-fill or mid-drain SHALL abandon the partial tile; no stale sa_valid after reset.

Structure
REQ-037 N, DW and typedef elem_t (logic [DW-1:0]) SHALL live in shared package tc_pkg.
REQ-038 The lane vector typedef (elem_t [N-1:0]) SHALL live in tc_pkg.
REQ-039 Each ping-pong buffer SHALL be one instance of sub-module tile_buffer: N x N register array, one row write port, full-tile parallel read.
REQ-040 Skew muxing and both FSMs SHALL be in tile_skew_loader.

Verification
REQ-041 Single tile: feed 8 beats with element (r,k) = 16*r+k, sa_ready=1. Lane 3 SHALL output 0x30..0x37 at cnt 3..10 with sa_valid[3] high only there; sa_start at cnt 0; sa_last at cnt 14.
REQ-042 Ping-pong: stream 16 beats continuously with sa_ready=1. The second tile's sa_start SHALL follow the first tile's sa_last by exactly 1 cycle; in_ready never drops.
REQ-043 Backpressure: sa_ready=0, send 17 beats. Beat 16 accepted; in_ready=0 after beat 16; beat 17 held; no sa_valid. Raise sa_ready: drain starts; in_ready returns 1 the cycle after the first sa_last.
REQ-044 sa_ready toggled 1/0 every cycle during a drain: all 15 drain cycles SHALL proceed uninterrupted with correct data.
REQ-045 Assert rst at drain cnt=5 and mid-fill of the other buffer after 3 beats. Next cycle sa_valid=0, busy=0, in_ready=1; a fresh 8-beat tile then drains correctly.
REQ-046 in_valid=0 gaps between beats, e.g. beats on alternate cycles: the tile SHALL assemble identically to the contiguous case.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types for the tile loader: tile geometry, element and lane-vector types,
// and the drain FSM encoding.
package tc_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;

  typedef logic [DW-1:0] elem_t;
  typedef elem_t [N-1:0] lane_t;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } drain_st_e;

endpackage

// File: rtl/tile_buffer.sv
// One N x N tile store: a single row write port and a full-tile parallel read.
// Contents are not reset; the owner's full flag says when they are meaningful.
module tile_buffer #(
  parameter int unsigned N  = tc_pkg::N,
  parameter int unsigned DW = tc_pkg::DW,
  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [RowW-1:0]              wr_row_i,
  input  logic [N*DW-1:0]              wr_data_i,
  output logic [N-1:0][N-1:0][DW-1:0]  tile_o
);

  logic [N-1:0][N-1:0][DW-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_row_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tile_o = mem_q;

endmodule

// File: rtl/tile_skew_loader.sv
// Ping-pong tile loader: rows stream in over a valid/ready port, and each full tile
// is drained into the systolic array with lane i delayed by i cycles.
module tile_skew_loader #(
  parameter int unsigned N  = tc_pkg::N,
  parameter int unsigned DW = tc_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [N*DW-1:0]        in_data,
  output logic                   in_ready,
  input  logic                   sa_ready,
  output logic [N-1:0][DW-1:0]   sa_data,
  output logic [N-1:0]           sa_valid,
  output logic                   sa_start,
  output logic                   sa_last,
  output logic                   busy
);

  import tc_pkg::*;

  localparam int unsigned RowW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW    = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam int unsigned LastCnt = 2 * N - 2;

  drain_st_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RowW-1:0] row_q, row_d;
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [1:0]      full_q, full_d;

  logic accept;
  logic drain_done;
  logic [N-1:0][N-1:0][DW-1:0] tiles [2];

  for (genvar b = 0; b < 2; b++) begin : g_buf
    tile_buffer #(
      .N  (N),
      .DW (DW)
    ) u_tile_buffer (
      .clk       (clk),
      .wr_en_i   (accept && (wr_sel_q == 1'(b))),
      .wr_row_i  (row_q),
      .wr_data_i (in_data),
      .tile_o    (tiles[b])
    );
  end

  assign in_ready   = !full_q[wr_sel_q];
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q == StDrain);
  assign drain_done = busy && (cnt_q == CntW'(LastCnt));

  // Fill side: the two full-flag updates always target different buffers.
  always_comb begin
    row_d    = row_q;
    wr_sel_d = wr_sel_q;
    full_d   = full_q;
    if (drain_done) begin
      full_d[rd_sel_q] = 1'b0;
    end
    if (accept) begin
      if (row_q == RowW'(N - 1)) begin
        row_d            = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        row_d = row_q + RowW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_sel_d = rd_sel_q;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_sel_q] && sa_ready) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (drain_done) begin
          rd_sel_d = ~rd_sel_q;
          cnt_d    = '0;
          state_d  = (full_q[~rd_sel_q] && sa_ready) ? StDrain : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      row_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
    end
  end

  assign sa_start = busy && (cnt_q == '0);
  assign sa_last  = drain_done;

  // Lane i carries row i, column cnt-i, so the tile enters the array as a wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CntW-1:0] col;
    logic            in_win;
    assign col         = cnt_q - CntW'(i);
    assign in_win      = busy && (cnt_q >= CntW'(i)) && (col <= CntW'(N - 1));
    assign sa_valid[i] = in_win;
    assign sa_data[i]  = in_win ? tiles[rd_sel_q][i][col[RowW-1:0]] : '0;
  end

endmodule

// File: tb/tb_tile_skew_loader.sv
// Scoreboard bench for tile_skew_loader: the driver queues each tile's expected
// wavefront when the tile is complete; a negedge monitor pops one entry per drain cycle.
module tb_tile_skew_loader;

  localparam int N      = 8;
  localparam int DW     = 32;
  localparam int Budget = 200;

  typedef struct packed {
    logic [N-1:0]          v;
    logic [N-1:0][DW-1:0]  d;
    logic                  s;
    logic                  l;
  } rec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic [N*DW-1:0]       in_data;
  logic                  in_ready;
  logic                  sa_ready;
  logic [N-1:0][DW-1:0]  sa_data;
  logic [N-1:0]          sa_valid;
  logic                  sa_start;
  logic                  sa_last;
  logic                  busy;

  rec_t exp_q[$];
  int   start_q[$];
  int   last_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  tile_skew_loader #(
    .N  (N),
    .DW (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .sa_ready (sa_ready),
    .sa_data  (sa_data),
    .sa_valid (sa_valid),
    .sa_start (sa_start),
    .sa_last  (sa_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %s, expected %s (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [DW-1:0] elem(input int base, input int r, input int k);
    return DW'(base + 16 * r + k);
  endfunction

  function automatic logic [N*DW-1:0] row_data(input int base, input int r);
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = elem(base, r, k);
    return d;
  endfunction

  // Lane i, cycle t: row i, column t-i when that column exists.
  task automatic push_expected(input int base);
    rec_t e;
    for (int t = 0; t <= 2 * N - 2; t++) begin
      e = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i <= N - 1) begin
          e.v[i] = 1'b1;
          e.d[i] = elem(base, i, t - i);
        end
      end
      e.s = (t == 0);
      e.l = (t == 2 * N - 2);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (mon_en && !rst) begin
      if (busy) begin
        if (sa_start) start_q.push_back(cyc);
        if (sa_last) last_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_drain", $sformatf("busy v=%h", sa_valid), "idle");
        end else begin
          e = exp_q.pop_front();
          chk({sa_valid, sa_data, sa_start, sa_last} == e, "drain_beat",
              $sformatf("%h", {sa_valid, sa_data, sa_start, sa_last}), $sformatf("%h", e));
        end
      end else begin
        chk(sa_valid == '0 && sa_data == '0 && !sa_start && !sa_last, "idle_zero",
            $sformatf("v=%h s=%b l=%b", sa_valid, sa_start, sa_last), "all zero");
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [N*DW-1:0] d, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < Budget) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk(1'b0, "accept_timeout", "in_ready=0", "in_ready=1");
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_tile(input int base, input int gap, output int max_wait);
    int w;
    max_wait = 0;
    for (int r = 0; r < N; r++) begin
      send_beat(row_data(base, r), w);
      if (w > max_wait) max_wait = w;
      if (r != N - 1) repeat (gap) @(negedge clk);
    end
    push_expected(base);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < Budget) begin
      @(negedge clk);
      n++;
    end
    chk(exp_q.size() == 0 && !busy, "drain_complete",
        $sformatf("pending=%0d busy=%b", exp_q.size(), busy), "pending=0 busy=0");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    sa_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk(in_ready == 1'b1, "reset_in_ready", $sformatf("%b", in_ready), "1");
    chk(!busy && sa_valid == '0 && !sa_start && !sa_last, "reset_outputs",
        $sformatf("busy=%b v=%h", busy, sa_valid), "all zero");
    mon_en = 1'b1;

    // Single tile, element (r,k) = 16r+k.
    sa_ready = 1'b1;
    send_tile(0, 0, w);
    wait_drained();

    // Two tiles streamed back to back.
    start_q.delete();
    last_q.delete();
    send_tile('h100, 0, w);
    send_tile('h200, 0, w2);
    chk(w == 0 && w2 == 0, "pingpong_in_ready", $sformatf("stall %0d/%0d", w, w2), "0/0");
    wait_drained();
    chk(start_q.size() == 2 && last_q.size() == 2 && start_q[start_q.size()-1] == last_q[0] + 1,
        "b2b_gap", $sformatf("starts=%0d lasts=%0d", start_q.size(), last_q.size()),
        "second start one cycle after first last");

    // Backpressure: both buffers fill, beat 17 is held.
    sa_ready = 1'b0;
    send_tile('h300, 0, w);
    send_tile('h400, 0, w);
    chk(in_ready == 1'b0, "full_in_ready_low", $sformatf("%b", in_ready), "0");
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = row_data('hDE00 + i, i);
      @(negedge clk);
      chk(!in_ready && !busy, "hold_stall", $sformatf("rdy=%b busy=%b", in_ready, busy),
          "rdy=0 busy=0");
    end
    in_data = row_data('h500, 0);
    last_q.delete();
    sa_ready = 1'b1;
    n = 0;
    while (!in_ready && n < Budget) begin
      @(negedge clk);
      n++;
    end
    chk(last_q.size() >= 1 && cyc == last_q[0] + 1, "in_ready_return",
        $sformatf("cycle %0d", cyc), "first sa_last cycle + 1");
    @(negedge clk);
    in_valid = 1'b0;
    for (int r = 1; r < N; r++) send_beat(row_data('h500, r), w);
    push_expected('h500);
    wait_drained();

    // sa_ready toggling mid-drain must not stall the wavefront.
    send_tile('h600, 0, w);
    n = 0;
    while (!busy && n < Budget) begin
      @(negedge clk);
      n++;
    end
    repeat (16) begin
      sa_ready = ~sa_ready;
      @(negedge clk);
    end
    sa_ready = 1'b1;
    wait_drained();

    // Reset at drain cnt=5 with the other buffer three rows into its fill.
    send_tile('h700, 0, w);
    for (int r = 0; r < 3; r++) send_beat(row_data('h800, r), w);
    repeat (3) @(negedge clk);
    chk(busy && sa_valid == 8'h3F, "pre_reset_cnt5", $sformatf("busy=%b v=%h", busy, sa_valid),
        "busy=1 v=3f");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk(sa_valid == '0 && !busy && in_ready, "post_reset",
        $sformatf("v=%h busy=%b rdy=%b", sa_valid, busy, in_ready), "v=0 busy=0 rdy=1");
    send_tile('h900, 0, w);
    wait_drained();

    // Beats on alternate cycles.
    send_tile('hA00, 1, w);
    wait_drained();

    chk(exp_q.size() == 0, "queue_empty", $sformatf("%0d", exp_q.size()), "0");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
